// File: rtl/red_exec.sv
// Single-issue accumulator execute stage: one instruction per enabled cycle,
// a 4-entry register file, branch requests to fetch and a post-branch squash window.
module red_exec #(
    parameter int BR_SHADOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] opCode_in,
    output logic        BR,
    output logic [15:0] br_target,
    output logic [15:0] acc,
    output logic        zf,
    output logic        cf,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SHADOW = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0] SHADOW_INIT = BR_SHADOW[1:0];

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_STR  = 4'h9;
    localparam logic [3:0] OP_LDR  = 4'hA;
    localparam logic [3:0] OP_ADDR = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JNZ  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t      state, nxt_state;
    logic [1:0]  cnt, nxt_cnt;
    logic [15:0] rf [4];

    logic [15:0] nxt_acc, nxt_target, nxt_retired;
    logic        nxt_zf, nxt_cf, nxt_br;
    logic        rf_we;

    logic [3:0]  op;
    logic [15:0] imm16;
    logic [1:0]  ridx;
    logic [15:0] rval;
    logic [16:0] sum_imm, sum_reg, diff_imm;
    logic        acc_write;
    logic        taken;

    assign op       = opCode_in[15:12];
    assign imm16    = {4'h0, opCode_in[11:0]};
    assign ridx     = opCode_in[1:0];
    assign rval     = rf[ridx];
    assign sum_imm  = {1'b0, acc} + {1'b0, imm16};
    assign sum_reg  = {1'b0, acc} + {1'b0, rval};
    assign diff_imm = {1'b0, acc} - {1'b0, imm16};
    assign halted   = (state == HALTED);

    // Next-state and datapath results; flags use pre-edge zf for branch decisions.
    always_comb begin
        nxt_state   = state;
        nxt_cnt     = cnt;
        nxt_acc     = acc;
        nxt_zf      = zf;
        nxt_cf      = cf;
        nxt_br      = 1'b0;
        nxt_target  = br_target;
        nxt_retired = retired;
        rf_we       = 1'b0;
        acc_write   = 1'b0;
        taken       = 1'b0;

        case (state)
            RUN: begin
                nxt_retired = retired + 16'd1;
                case (op)
                    OP_NOP:  ;
                    OP_LDI:  begin nxt_acc = imm16; acc_write = 1'b1; end
                    OP_ADDI: begin
                        nxt_acc = sum_imm[15:0]; nxt_cf = sum_imm[16]; acc_write = 1'b1;
                    end
                    OP_SUBI: begin
                        nxt_acc = diff_imm[15:0]; nxt_cf = diff_imm[16]; acc_write = 1'b1;
                    end
                    OP_ANDI: begin nxt_acc = acc & imm16; acc_write = 1'b1; end
                    OP_ORI:  begin nxt_acc = acc | imm16; acc_write = 1'b1; end
                    OP_XORI: begin nxt_acc = acc ^ imm16; acc_write = 1'b1; end
                    OP_SHL:  begin
                        nxt_acc = {acc[14:0], 1'b0}; nxt_cf = acc[15]; acc_write = 1'b1;
                    end
                    OP_SHR:  begin
                        nxt_acc = {1'b0, acc[15:1]}; nxt_cf = acc[0]; acc_write = 1'b1;
                    end
                    OP_STR:  rf_we = 1'b1;
                    OP_LDR:  begin nxt_acc = rval; acc_write = 1'b1; end
                    OP_ADDR: begin
                        nxt_acc = sum_reg[15:0]; nxt_cf = sum_reg[16]; acc_write = 1'b1;
                    end
                    OP_JMP:  taken = 1'b1;
                    OP_JZ:   taken = zf;
                    OP_JNZ:  taken = ~zf;
                    OP_HLT:  nxt_state = HALTED;
                    default: ;
                endcase

                if (acc_write) begin
                    nxt_zf = (nxt_acc == 16'h0000);
                end

                if (taken) begin
                    nxt_br     = 1'b1;
                    nxt_target = imm16;
                    if (BR_SHADOW != 0) begin
                        nxt_state = SHADOW;
                        nxt_cnt   = SHADOW_INIT;
                    end
                end
            end

            SHADOW: begin
                nxt_cnt = cnt - 2'd1;
                if (cnt <= 2'd1) begin
                    nxt_state = RUN;
                    nxt_cnt   = 2'd0;
                end
            end

            HALTED: ;

            default: begin
                nxt_state = RUN;
                nxt_cnt   = 2'd0;
            end
        endcase
    end

    // Architectural state; everything holds while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= 2'd0;
            acc       <= 16'h0000;
            zf        <= 1'b0;
            cf        <= 1'b0;
            BR        <= 1'b0;
            br_target <= 16'h0000;
            retired   <= 16'h0000;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 16'h0000;
            end
        end else if (en) begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            acc       <= nxt_acc;
            zf        <= nxt_zf;
            cf        <= nxt_cf;
            BR        <= nxt_br;
            br_target <= nxt_target;
            retired   <= nxt_retired;
            if (rf_we) begin
                rf[ridx] <= acc;
            end
        end
    end

endmodule

// File: tb/tb_red_exec.sv
// Directed testbench for red_exec with BR_SHADOW=1; expected values are hand-computed.
module tb_red_exec;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] opCode_in;
    logic        BR;
    logic [15:0] br_target;
    logic [15:0] acc;
    logic        zf;
    logic        cf;
    logic        halted;
    logic [15:0] retired;

    int checks;
    int failures;

    red_exec #(.BR_SHADOW(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .opCode_in (opCode_in),
        .BR        (BR),
        .br_target (br_target),
        .acc       (acc),
        .zf        (zf),
        .cf        (cf),
        .halted    (halted),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word with en=1 and land 1ns after the sampling edge.
    task automatic exec(input logic [15:0] w);
        opCode_in = w;
        en        = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        en        = 1'b0;
        opCode_in = 16'h0000;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b1;
        opCode_in = 16'h1005;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({acc, zf, cf, BR, br_target, halted, retired} !== {16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL reset_state acc=%h zf=%b cf=%b BR=%b tgt=%h halted=%b ret=%h required all zero",
                     acc, zf, cf, BR, br_target, halted, retired);
        end
        do_reset();
    endtask

    task automatic test_add();
        do_reset();
        exec(16'h1005);
        exec(16'h2003);
        checks++;
        if ({acc, zf, cf, retired} !== {16'h0008, 1'b0, 1'b0, 16'd2}) begin
            failures++;
            $display("FAIL ldi_addi acc=%h zf=%b cf=%b ret=%0d required acc=0008 zf=0 cf=0 ret=2",
                     acc, zf, cf, retired);
        end
    endtask

    task automatic test_sub_wrap();
        do_reset();
        exec(16'h1001);
        exec(16'h3002);
        checks++;
        if ({acc, zf, cf} !== {16'hFFFF, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL subi_borrow acc=%h zf=%b cf=%b required acc=ffff zf=0 cf=1", acc, zf, cf);
        end
        exec(16'h2001);
        checks++;
        if ({acc, zf, cf, retired} !== {16'h0000, 1'b1, 1'b1, 16'd3}) begin
            failures++;
            $display("FAIL addi_carry acc=%h zf=%b cf=%b ret=%0d required acc=0000 zf=1 cf=1 ret=3",
                     acc, zf, cf, retired);
        end
    endtask

    task automatic test_logic_shift();
        do_reset();
        exec(16'h10F0);
        exec(16'h40FF);
        checks++;
        if (acc !== 16'h00F0) begin
            failures++;
            $display("FAIL andi acc=%h required 00f0", acc);
        end
        exec(16'h500F);
        checks++;
        if (acc !== 16'h00FF) begin
            failures++;
            $display("FAIL ori acc=%h required 00ff", acc);
        end
        exec(16'h60FF);
        checks++;
        if ({acc, zf} !== {16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL xori acc=%h zf=%b required acc=0000 zf=1", acc, zf);
        end
        exec(16'h1801);
        exec(16'h8000);
        checks++;
        if ({acc, cf, zf} !== {16'h0400, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL shr acc=%h cf=%b zf=%b required acc=0400 cf=1 zf=0", acc, cf, zf);
        end
        exec(16'h7000);
        checks++;
        if ({acc, cf} !== {16'h0800, 1'b0}) begin
            failures++;
            $display("FAIL shl acc=%h cf=%b required acc=0800 cf=0", acc, cf);
        end
        exec(16'h0000);
        checks++;
        if ({acc, cf, retired} !== {16'h0800, 1'b0, 16'd8}) begin
            failures++;
            $display("FAIL nop acc=%h cf=%b ret=%0d required acc=0800 cf=0 ret=8", acc, cf, retired);
        end
    endtask

    task automatic test_branch();
        do_reset();
        exec(16'hC040);
        checks++;
        if ({BR, br_target, acc, retired} !== {1'b1, 16'h0040, 16'h0000, 16'd1}) begin
            failures++;
            $display("FAIL jmp_taken BR=%b tgt=%h acc=%h ret=%0d required BR=1 tgt=0040 acc=0000 ret=1",
                     BR, br_target, acc, retired);
        end
        exec(16'h2001);
        checks++;
        if ({BR, br_target, acc, retired} !== {1'b0, 16'h0040, 16'h0000, 16'd1}) begin
            failures++;
            $display("FAIL jmp_squash BR=%b tgt=%h acc=%h ret=%0d required BR=0 tgt=0040 acc=0000 ret=1",
                     BR, br_target, acc, retired);
        end
        exec(16'h2001);
        checks++;
        if ({acc, retired} !== {16'h0001, 16'd2}) begin
            failures++;
            $display("FAIL post_shadow acc=%h ret=%0d required acc=0001 ret=2", acc, retired);
        end
        exec(16'hE123);
        exec(16'hF000);
        checks++;
        if ({halted, BR, br_target, retired} !== {1'b0, 1'b0, 16'h0123, 16'd3}) begin
            failures++;
            $display("FAIL jnz_shadow_hlt halted=%b BR=%b tgt=%h ret=%0d required halted=0 BR=0 tgt=0123 ret=3",
                     halted, BR, br_target, retired);
        end
    endtask

    task automatic test_not_taken_rf();
        do_reset();
        exec(16'h1001);
        exec(16'hD010);
        checks++;
        if ({BR, br_target} !== {1'b0, 16'h0000}) begin
            failures++;
            $display("FAIL jz_not_taken BR=%b tgt=%h required BR=0 tgt=0000", BR, br_target);
        end
        exec(16'h2001);
        checks++;
        if ({acc, retired} !== {16'h0002, 16'd3}) begin
            failures++;
            $display("FAIL jz_nop_path acc=%h ret=%0d required acc=0002 ret=3", acc, retired);
        end
        exec(16'h9002);
        exec(16'h1000);
        exec(16'hA002);
        checks++;
        if ({acc, zf} !== {16'h0002, 1'b0}) begin
            failures++;
            $display("FAIL str_ldr acc=%h zf=%b required acc=0002 zf=0", acc, zf);
        end
        exec(16'hB002);
        checks++;
        if ({acc, cf, retired} !== {16'h0004, 1'b0, 16'd7}) begin
            failures++;
            $display("FAIL addr acc=%h cf=%b ret=%0d required acc=0004 cf=0 ret=7", acc, cf, retired);
        end
        exec(16'hA001);
        checks++;
        if ({acc, zf} !== {16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL ldr_unwritten acc=%h zf=%b required acc=0000 zf=1", acc, zf);
        end
    endtask

    task automatic test_halt_reset();
        do_reset();
        exec(16'h1005);
        exec(16'hF000);
        exec(16'h1123);
        checks++;
        if ({halted, acc, retired, BR} !== {1'b1, 16'h0005, 16'd2, 1'b0}) begin
            failures++;
            $display("FAIL halted halted=%b acc=%h ret=%0d BR=%b required halted=1 acc=0005 ret=2 BR=0",
                     halted, acc, retired, BR);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({acc, zf, cf, BR, br_target, halted, retired} !== {16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL async_reset acc=%h zf=%b cf=%b BR=%b tgt=%h halted=%b ret=%h required all zero",
                     acc, zf, cf, BR, br_target, halted, retired);
        end
        rst_n = 1'b1;
        exec(16'h1007);
        checks++;
        if ({acc, retired, halted} !== {16'h0007, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL after_reset acc=%h ret=%0d halted=%b required acc=0007 ret=1 halted=0",
                     acc, retired, halted);
        end
    endtask

    task automatic test_enable();
        do_reset();
        exec(16'h1005);
        exec(16'hC020);
        en        = 1'b0;
        opCode_in = 16'h2001;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({BR, acc, retired} !== {1'b1, 16'h0005, 16'd2}) begin
                failures++;
                $display("FAIL en_hold cycle=%0d BR=%b acc=%h ret=%0d required BR=1 acc=0005 ret=2",
                         i, BR, acc, retired);
            end
        end
        exec(16'h2001);
        checks++;
        if ({BR, acc, retired} !== {1'b0, 16'h0005, 16'd2}) begin
            failures++;
            $display("FAIL en_resume_squash BR=%b acc=%h ret=%0d required BR=0 acc=0005 ret=2",
                     BR, acc, retired);
        end
        exec(16'h2001);
        checks++;
        if ({acc, retired} !== {16'h0006, 16'd3}) begin
            failures++;
            $display("FAIL en_resume_exec acc=%h ret=%0d required acc=0006 ret=3", acc, retired);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exec(16'hC010);
        exec(16'hC020);
        checks++;
        if ({BR, br_target} !== {1'b0, 16'h0010}) begin
            failures++;
            $display("FAIL b2b_squashed BR=%b tgt=%h required BR=0 tgt=0010", BR, br_target);
        end
        exec(16'hC030);
        checks++;
        if ({BR, br_target, retired} !== {1'b1, 16'h0030, 16'd2}) begin
            failures++;
            $display("FAIL b2b_second BR=%b tgt=%h ret=%0d required BR=1 tgt=0030 ret=2",
                     BR, br_target, retired);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        opCode_in = 16'h0000;
        test_reset();
        test_add();
        test_sub_wrap();
        test_logic_shift();
        test_branch();
        test_not_taken_rf();
        test_halt_reset();
        test_enable();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
